step_record_sequencer: RTL and testbench

//  Drains 16-bit motion records from the SPI-fed record FIFO and turns each one into
//  a step pulse on the 8 output pins, followed by a timed dwell.

---
 rtl/step_seq_pkg.sv | 29 ++
 rtl/step_record_sequencer_tick_prescaler.sv | 32 +++
 rtl/step_record_sequencer.sv | 131 +++++++++++++
 tb/tb_step_record_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_seq_pkg.sv
// step_seq_pkg: shared types, field widths and record field helpers for the
// step record sequencer.
// A record is {step mask, dwell ticks}. The mask has one bit per output pin and
// occupies the upper byte. Dwell ticks occupy the lower byte.
package step_seq_pkg;

  localparam int MASK_W  = 8;
  localparam int DWELL_W = 8;
  localparam int REC_W   = MASK_W + DWELL_W;

  // FSM state encoding. Plain constants keep the encoding fixed for legacy
  // tooling that inspects the state register.
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t FETCH = 2'd1;
  localparam state_t PULSE = 2'd2;
  localparam state_t DWELL = 2'd3;

  // Step mask field of a record.
  function automatic logic [MASK_W-1:0] rec_mask(input logic [REC_W-1:0] rec);
    return rec[REC_W-1:DWELL_W];
  endfunction

  // Dwell tick count field of a record.
  function automatic logic [DWELL_W-1:0] rec_dwell(input logic [REC_W-1:0] rec);
    return rec[DWELL_W-1:0];
  endfunction

endpackage

// File: rtl/step_record_sequencer_tick_prescaler.sv
// tick_prescaler: divides clk by TICK_DIV and emits a one-cycle tick.
// While restart is high the count is held at 0. The first tick therefore
// lands TICK_DIV cycles after restart drops.
module tick_prescaler #(
  parameter int TICK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  assign tick = !restart && (cnt == LAST);

  // Free-running modulo-TICK_DIV count, held at zero during restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/step_record_sequencer.sv
// step_record_sequencer: pops motion records from a show-ahead FIFO. For each
// record it drives a step pulse on the 8 pins, then waits for a timed dwell.
// Optional feature macro STEP_SEQ_COUNT_EN adds a 32-bit count of fetched
// records that had a non-zero step mask.
module step_record_sequencer
  import step_seq_pkg::*;
#(
  parameter int RECORD_W     = 16,
  parameter int PULSE_CYCLES = 8,
  parameter int TICK_DIV     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                fifo_empty,
  input  logic [RECORD_W-1:0] fifo_data,
  output logic                fifo_read_en,
  output logic [MASK_W-1:0]   step_out,
  output logic                busy,
  output logic                underrun,
`ifdef STEP_SEQ_COUNT_EN
  output logic [31:0]         step_count,
`endif
  input  logic                clear_underrun
);

  localparam int PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PCW-1:0]     PULSE_LAST = PCW'(PULSE_CYCLES - 1);
  localparam logic [PCW-1:0]     PULSE_ONE  = PCW'(1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  state_t             state;
  state_t             state_nxt;
  logic [PCW-1:0]     pulse_cnt;
  logic [DWELL_W-1:0] dwell_left;
  logic               tick;
  logic               pulse_last;
  logic               dwell_last;
  logic               rec_end;
  logic               underrun_set;
  logic [REC_W-1:0]   head_rec;

  assign head_rec     = fifo_data[REC_W-1:0];
  assign fifo_read_en = (state == FETCH) && !fifo_empty;
  assign busy         = (state != IDLE);
  assign pulse_last   = (state == PULSE) && (pulse_cnt == PULSE_LAST);
  assign dwell_last   = (state == DWELL) && tick && (dwell_left == DWELL_ONE);
  // A record ends after its last pulse cycle if it has no dwell. Otherwise it
  // ends on the final dwell tick.
  assign rec_end      = (pulse_last && dwell_left == '0) || dwell_last;

  // The prescaler starts each dwell from zero, so a dwell lasts exactly dwell*TICK_DIV cycles.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state != DWELL),
    .tick    (tick)
  );

  // Next-state decode; the end-of-record decision chains straight into FETCH when work is queued.
  always_comb begin
    state_nxt    = state;
    underrun_set = 1'b0;
    case (state)
      IDLE:    if (enable && !fifo_empty) state_nxt = FETCH;
      FETCH:   state_nxt = PULSE;
      PULSE:   if (pulse_last && dwell_left != '0) state_nxt = DWELL;
      DWELL:   state_nxt = DWELL;
      default: state_nxt = IDLE;
    endcase
    if (rec_end) begin
      if (enable && !fifo_empty) begin
        state_nxt = FETCH;
      end else begin
        state_nxt    = IDLE;
        underrun_set = enable;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Record latch, pulse timing and dwell countdown. step_out is high for the whole PULSE state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_out   <= '0;
      pulse_cnt  <= '0;
      dwell_left <= '0;
    end else begin
      case (state)
        FETCH: begin
          step_out   <= rec_mask(head_rec);
          dwell_left <= rec_dwell(head_rec);
          pulse_cnt  <= '0;
        end
        PULSE: begin
          pulse_cnt <= pulse_cnt + PULSE_ONE;
          if (pulse_last) step_out <= '0;
        end
        DWELL: begin
          if (tick) dwell_left <= dwell_left - DWELL_ONE;
        end
        default: step_out <= '0;
      endcase
    end
  end

  // Sticky underrun flag; a new underrun outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              underrun <= 1'b0;
    else if (underrun_set)   underrun <= 1'b1;
    else if (clear_underrun) underrun <= 1'b0;
  end

`ifdef STEP_SEQ_COUNT_EN
  // Count fetched records that actually step a pin; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      step_count <= '0;
    else if (fifo_read_en && rec_mask(head_rec) != '0)
      step_count <= step_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_step_record_sequencer.sv
// Bench for step_record_sequencer with PULSE_CYCLES=2 and TICK_DIV=4.
// The reference model tracks each record by its age within the record period.
// It derives the expected pins, pop strobe, busy and underrun from that age.
module tb_step_record_sequencer;

  localparam int P = 2;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear_underrun = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        fifo_read_en;
  logic [7:0]  step_out;
  logic        busy;
  logic        underrun;
`ifdef STEP_SEQ_COUNT_EN
  logic [31:0] step_count;
`endif

  always #5 clk = ~clk;

  step_record_sequencer #(
    .RECORD_W     (16),
    .PULSE_CYCLES (P),
    .TICK_DIV     (T)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_data      (fifo_data),
    .fifo_read_en   (fifo_read_en),
    .step_out       (step_out),
    .busy           (busy),
    .underrun       (underrun),
`ifdef STEP_SEQ_COUNT_EN
    .step_count     (step_count),
`endif
    .clear_underrun (clear_underrun)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] fq[$];
  logic [15:0] mq[$];
  bit          pend_pop = 1'b0;

  bit          m_active = 1'b0;
  bit          m_und    = 1'b0;
  int          m_age    = 0;
  int          m_len    = 0;
  logic [7:0]  m_mask   = '0;
  logic [31:0] m_cnt    = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic sync_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : 16'h0000;
  endtask

  task automatic push(input logic [15:0] r);
    fq.push_back(r);
    mq.push_back(r);
    sync_fifo();
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_und    = 1'b0;
    m_age    = 0;
    m_len    = 0;
    m_mask   = '0;
    m_cnt    = '0;
  endtask

  // Advance the model by one clock edge using the inputs held over the cycle.
  task automatic model_edge();
    bit          start;
    bit          und_set;
    logic [15:0] rec;
    start   = 1'b0;
    und_set = 1'b0;
    if (m_active) begin
      if (m_age == 0 && m_mask != 8'h00) m_cnt = m_cnt + 32'd1;
      if (m_age == m_len - 1) begin
        m_active = 1'b0;
        if (enable && mq.size() > 0) start = 1'b1;
        else if (enable)             und_set = 1'b1;
      end else begin
        m_age++;
      end
    end else if (enable && mq.size() > 0) begin
      start = 1'b1;
    end
    if (start) begin
      rec      = mq.pop_front();
      m_active = 1'b1;
      m_age    = 0;
      m_mask   = rec[15:8];
      m_len    = 1 + P + int'(rec[7:0]) * T;
    end
    if (und_set)             m_und = 1'b1;
    else if (clear_underrun) m_und = 1'b0;
  endtask

  task automatic check_outputs();
    logic [7:0] exp_step;
    exp_step = (m_active && m_age >= 1 && m_age <= P) ? m_mask : 8'h00;
    chk("step_out", step_out, exp_step);
    chk("read_en", fifo_read_en, m_active && m_age == 0);
    chk("busy", busy, m_active);
    chk("underrun", underrun, m_und);
    chk("pop_while_empty", fifo_read_en && fifo_empty, 1'b0);
`ifdef STEP_SEQ_COUNT_EN
    chk("step_count", step_count, m_cnt);
`endif
  endtask

  // One clock: model steps at the active edge, DUT sampled on the falling edge.
  // A pop seen in the FETCH cycle leaves the FIFO after the edge that latched it.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    @(negedge clk);
    check_outputs();
    if (pend_pop) begin
      chk("pop_nonempty", fq.size() != 0, 1'b1);
      if (fq.size() != 0) void'(fq.pop_front());
    end
    pend_pop = fifo_read_en;
    sync_fifo();
  endtask

  task automatic wait_fetch(input string tag);
    int k;
    k = 0;
    while (!fifo_read_en && k < 20) begin
      tick();
      k++;
    end
    chk(tag, fifo_read_en, 1'b1);
  endtask

  initial begin
    int k;
    int n;
    sync_fifo();
    repeat (3) tick();
    chk("reset_step", step_out, 8'h00);
    chk("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // T1: single record, pulse then 5-tick dwell, then underrun
    push(16'h0F05);
    enable = 1'b1;
    wait_fetch("t1_fetch");
    k = 0;
    do begin
      tick();
      k++;
    end while (busy && k < 60);
    chk("t1_busy_fall", k, 23);
    chk("t1_underrun", underrun, 1'b1);
    enable = 1'b0;
    tick();
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    tick();

    // T2: three back-to-back records
    push(16'h0100);
    push(16'h0201);
    push(16'h0400);
    enable = 1'b1;
    n = 0;
    repeat (30) begin
      tick();
      if (fifo_read_en) n++;
    end
    chk("t2_pops", n, 3);
    enable = 1'b0;
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    tick();

    // T3: enable dropped mid-pulse, remaining records stay queued
    push(16'h8003);
    push(16'h0101);
    push(16'h0102);
    enable = 1'b1;
    k = 0;
    while (step_out == 8'h00 && k < 20) begin
      tick();
      k++;
    end
    chk("t3_pulse", step_out, 8'h80);
    enable = 1'b0;
    repeat (30) tick();
    chk("t3_left", fq.size(), 2);
    chk("t3_underrun", underrun, 1'b0);
    chk("t3_idle", busy, 1'b0);
    fq.delete();
    mq.delete();
    sync_fifo();
    tick();

    // T4: zero mask keeps uniform timing
    push(16'h0002);
    enable = 1'b1;
    wait_fetch("t4_fetch");
    n = 0;
    while (busy && n < 40) begin
      chk("t4_no_step", step_out, 8'h00);
      tick();
      n++;
    end
    chk("t4_period", n, 1 + P + 2 * T);
    chk("t4_underrun", underrun, 1'b1);
    enable = 1'b0;
    tick();

    // T6: clear coincident with a new underrun loses, then a lone clear wins
    push(16'h0100);
    enable = 1'b1;
    wait_fetch("t6_fetch");
    tick();
    tick();
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    chk("t6_set_wins", underrun, 1'b1);
    enable = 1'b0;
    tick();
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    chk("t6_clear", underrun, 1'b0);

    // T5: asynchronous reset in the middle of a dwell
    push(16'h0103);
    push(16'h0201);
    enable = 1'b1;
    wait_fetch("t5_fetch");
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_step", step_out, 8'h00);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_rd", fifo_read_en, 1'b0);
    chk("t5_rst_und", underrun, 1'b0);
    model_reset();
    pend_pop = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("t5_drained", fq.size(), 0);
    enable = 1'b0;
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    tick();

    // Randomized traffic: pushes, enable toggles and clears
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0 && fq.size() < 6)
        push({8'($urandom_range(0, 255)), 8'($urandom_range(0, 3))});
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      clear_underrun = ($urandom_range(0, 15) == 0);
      tick();
    end
    enable = 1'b0;
    clear_underrun = 1'b0;
    repeat (60) tick();
    chk("final_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
